cic_rate_ctrl: RTL and testbench

Rate-change sequencer placed in front of the CIC decimator's `s_axis_rate_*` port. It accepts decimation-rate requests over an AXI-Stream handshake, range-checks them, waits for a decimation boundary, and holds the filter in soft reset while its integrators flush. It then applies the new rate and blanks filter outputs until the comb chain has settled. This makes run-time rate changes glitch-free without any software timing.

---
 rtl/cic_rate_ctrl.sv | 153 +++++++++++++++
 tb/tb_cic_rate_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_rate_ctrl.sv
// Rate-change sequencer for the CIC decimator: accepts rate requests, waits for a
// decimation boundary, flushes the filter, applies the rate and blanks settling outputs.
module cic_rate_ctrl #(
   parameter int RATE_DW    = 32,
   parameter int CIC_R      = 10,
   parameter int CIC_N      = 7,
   parameter int CIC_M      = 1,
   parameter int FLUSH_CYC  = 4,
   parameter int SETTLE_CNT = CIC_N * CIC_M
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [RATE_DW-1:0] s_axis_cfg_tdata,
   input  logic               s_axis_cfg_tvalid,
   output logic               s_axis_cfg_tready,
   output logic               cfg_err,
   input  logic               s_axis_in_tvalid,
   output logic               cic_in_tvalid,
   input  logic               cic_out_tvalid,
   output logic               m_axis_out_tvalid,
   output logic               cic_reset_n,
   output logic [RATE_DW-1:0] cic_rate_tdata,
   output logic               cic_rate_tvalid,
   output logic [RATE_DW-1:0] current_rate,
   output logic               busy
);

   localparam int FW = $clog2(FLUSH_CYC + 1);
   localparam int SW = (SETTLE_CNT > 0) ? $clog2(SETTLE_CNT + 1) : 1;
   localparam logic [RATE_DW-1:0] L_RATE_MAX    = RATE_DW'(CIC_R);
   localparam logic [FW-1:0]      L_FLUSH_LAST  = FW'(FLUSH_CYC - 1);
   localparam logic [SW-1:0]      L_SETTLE_LAST = SW'(SETTLE_CNT - 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_BND,
      FLUSH,
      APPLY,
      SETTLE
   } state_t;

   state_t             r_state;
   logic [RATE_DW-1:0] r_pending;
   logic [RATE_DW-1:0] r_currentRate;
   logic [RATE_DW-1:0] r_rateData;
   logic [FW-1:0]      r_flushCnt;
   logic [SW-1:0]      r_settleCnt;
   logic               r_rateValid;
   logic               r_cfgErr;
   logic               r_tready;
   logic               r_cicResetN;
   logic               r_busy;
   logic               w_blockIn;
   logic               w_blockOut;

   // Registered outputs are set on the transition into the state they belong to,
   // so every output below is valid in the same cycle as the state it describes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= IDLE;
         r_pending     <= L_RATE_MAX;
         r_currentRate <= L_RATE_MAX;
         r_rateData    <= L_RATE_MAX;
         r_flushCnt    <= '0;
         r_settleCnt   <= '0;
         r_rateValid   <= 1'b0;
         r_cfgErr      <= 1'b0;
         r_tready      <= 1'b0;
         r_cicResetN   <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_cfgErr    <= 1'b0;
         r_rateValid <= 1'b0;
         r_cicResetN <= 1'b1;
         r_tready    <= 1'b0;
         r_busy      <= 1'b1;
         unique case (r_state)
            IDLE: begin
               r_tready <= 1'b1;
               r_busy   <= 1'b0;
               if (s_axis_cfg_tvalid && r_tready) begin
                  if ((s_axis_cfg_tdata == '0) || (s_axis_cfg_tdata > L_RATE_MAX)) begin
                     r_cfgErr <= 1'b1;
                  end else if (s_axis_cfg_tdata != r_currentRate) begin
                     r_pending <= s_axis_cfg_tdata;
                     r_state   <= WAIT_BND;
                     r_tready  <= 1'b0;
                     r_busy    <= 1'b1;
                  end
               end
            end
            WAIT_BND: begin
               if (cic_out_tvalid) begin
                  r_state     <= FLUSH;
                  r_flushCnt  <= '0;
                  r_cicResetN <= 1'b0;
               end
            end
            FLUSH: begin
               if (r_flushCnt == L_FLUSH_LAST) begin
                  r_state     <= APPLY;
                  r_rateValid <= 1'b1;
                  r_rateData  <= r_pending;
               end else begin
                  r_flushCnt  <= r_flushCnt + FW'(1);
                  r_cicResetN <= 1'b0;
               end
            end
            APPLY: begin
               r_currentRate <= r_pending;
               r_settleCnt   <= '0;
               if (SETTLE_CNT == 0) begin
                  r_state  <= IDLE;
                  r_tready <= 1'b1;
                  r_busy   <= 1'b0;
               end else begin
                  r_state <= SETTLE;
               end
            end
            SETTLE: begin
               // The pulse that completes the count is itself blanked; idle starts after it.
               if (cic_out_tvalid) begin
                  if (r_settleCnt == L_SETTLE_LAST) begin
                     r_state  <= IDLE;
                     r_tready <= 1'b1;
                     r_busy   <= 1'b0;
                  end else begin
                     r_settleCnt <= r_settleCnt + SW'(1);
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign w_blockIn  = (r_state == FLUSH) || (r_state == APPLY);
   assign w_blockOut = w_blockIn || (r_state == SETTLE);

   assign cic_in_tvalid     = s_axis_in_tvalid & ~w_blockIn;
   assign m_axis_out_tvalid = cic_out_tvalid & ~w_blockOut;

   assign s_axis_cfg_tready = r_tready;
   assign cfg_err           = r_cfgErr;
   assign cic_reset_n       = r_cicResetN;
   assign cic_rate_tdata    = r_rateData;
   assign cic_rate_tvalid   = r_rateValid;
   assign current_rate      = r_currentRate;
   assign busy              = r_busy;

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Scoreboard bench for cic_rate_ctrl: a timestamp-based reference model predicts each
// cycle's outputs and every rate load; monitors pop and compare as the DUT presents them.
module tb_cic_rate_ctrl;

   localparam int DW = 32;
   localparam int R  = 10;
   localparam int F  = 4;
   localparam int S  = 7;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [DW-1:0] cfgData = '0;
   logic          cfgValid = 1'b0;
   logic          cfgReady;
   logic          cfgErr;
   logic          inValid = 1'b0;
   logic          cicInValid;
   logic          cicOutValid = 1'b0;
   logic          outValid;
   logic          cicResetN;
   logic [DW-1:0] rateData;
   logic          rateValid;
   logic [DW-1:0] curRate;
   logic          busyOut;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          tready;
      bit          err;
      bit          cicIn;
      bit          mOut;
      bit          rstN;
      bit          rateV;
      bit          busy;
      int unsigned rateD;
      int unsigned cur;
   } exp_t;

   exp_t        expQ[$];
   int unsigned rateQ[$];

   // Reference model: a request is described by when it was accepted and when its
   // boundary arrived; flush/apply/settle windows follow from those timestamps.
   int          cyc = 0;
   int          accT = -1;
   int          bndT = -1;
   int          setCnt = 0;
   int unsigned mCur = R;
   int unsigned mPend = R;
   int unsigned mLoaded = R;
   bit          errPrev = 1'b0;

   cic_rate_ctrl #(
      .RATE_DW   (DW),
      .CIC_R     (R),
      .CIC_N     (7),
      .CIC_M     (1),
      .FLUSH_CYC (F),
      .SETTLE_CNT(S)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .s_axis_cfg_tdata (cfgData),
      .s_axis_cfg_tvalid(cfgValid),
      .s_axis_cfg_tready(cfgReady),
      .cfg_err          (cfgErr),
      .s_axis_in_tvalid (inValid),
      .cic_in_tvalid    (cicInValid),
      .cic_out_tvalid   (cicOutValid),
      .m_axis_out_tvalid(outValid),
      .cic_reset_n      (cicResetN),
      .cic_rate_tdata   (rateData),
      .cic_rate_tvalid  (rateValid),
      .current_rate     (curRate),
      .busy             (busyOut)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      check("tready", 64'(cfgReady), 64'(e.tready));
      check("cfg_err", 64'(cfgErr), 64'(e.err));
      check("cic_in_tvalid", 64'(cicInValid), 64'(e.cicIn));
      check("m_axis_out_tvalid", 64'(outValid), 64'(e.mOut));
      check("cic_reset_n", 64'(cicResetN), 64'(e.rstN));
      check("cic_rate_tvalid", 64'(rateValid), 64'(e.rateV));
      check("busy", 64'(busyOut), 64'(e.busy));
      check("cic_rate_tdata", 64'(rateData), 64'(e.rateD));
      check("current_rate", 64'(curRate), 64'(e.cur));
   endtask

   task automatic applyStimulus(input bit inV, input bit outV, input bit reqV, input int unsigned reqD);
      exp_t e;
      bit   done = 1'b0;
      bit   errNow = 1'b0;
      bit   newCur = 1'b0;
      @(posedge clk);
      #1;
      inValid     = inV;
      cicOutValid = outV;
      cfgValid    = reqV;
      cfgData     = DW'(reqD);
      e.cur   = mCur;
      e.err   = errPrev;
      e.cicIn = inV;
      e.mOut  = outV;
      e.rstN  = 1'b1;
      e.rateV = 1'b0;
      if (!(accT >= 0 && cyc > accT)) begin
         e.busy   = 1'b0;
         e.tready = 1'b1;
         if (reqV) begin
            if (reqD == 0 || reqD > R) begin
               errNow = 1'b1;
            end else if (reqD != mCur) begin
               accT   = cyc;
               bndT   = -1;
               setCnt = 0;
               mPend  = reqD;
            end
         end
      end else begin
         e.busy   = 1'b1;
         e.tready = 1'b0;
         if (bndT < 0) begin
            if (outV) bndT = cyc;
         end else if (cyc <= bndT + F) begin
            e.rstN  = 1'b0;
            e.cicIn = 1'b0;
            e.mOut  = 1'b0;
         end else if (cyc == bndT + F + 1) begin
            mLoaded = mPend;
            e.rateV = 1'b1;
            e.cicIn = 1'b0;
            e.mOut  = 1'b0;
            rateQ.push_back(mPend);
            newCur = 1'b1;
            if (S == 0) done = 1'b1;
         end else begin
            e.mOut = 1'b0;
            if (outV) begin
               setCnt++;
               if (setCnt == S) done = 1'b1;
            end
         end
      end
      e.rateD = mLoaded;
      expQ.push_back(e);
      if (newCur) mCur = mPend;
      if (done) accT = -1;
      errPrev = errNow;
      cyc++;
   endtask

   task automatic doReset(input int holdCycles);
      @(negedge clk);
      #1;
      reset_n     = 1'b0;
      cfgValid    = 1'b0;
      inValid     = 1'b1;
      cicOutValid = 1'b1;
      #1;
      check("rst tready", 64'(cfgReady), 64'(0));
      check("rst cic_reset_n", 64'(cicResetN), 64'(0));
      check("rst busy", 64'(busyOut), 64'(0));
      check("rst cfg_err", 64'(cfgErr), 64'(0));
      check("rst rate_tvalid", 64'(rateValid), 64'(0));
      check("rst rate_tdata", 64'(rateData), 64'(R));
      check("rst current_rate", 64'(curRate), 64'(R));
      check("rst in passthru", 64'(cicInValid), 64'(1));
      check("rst out passthru", 64'(outValid), 64'(1));
      repeat (holdCycles) @(posedge clk);
      @(negedge clk);
      #1;
      inValid     = 1'b0;
      cicOutValid = 1'b0;
      reset_n     = 1'b1;
      cyc     = 0;
      accT    = -1;
      bndT    = -1;
      setCnt  = 0;
      mCur    = R;
      mPend   = R;
      mLoaded = R;
      errPrev = 1'b0;
      expQ.delete();
      rateQ.delete();
   endtask

   always @(negedge clk) begin
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
   end

   always @(negedge clk) begin
      if (reset_n && rateValid) begin
         if (rateQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL rate_load cycle %0d: got load of %0d expected no load", cyc, rateData);
         end else begin
            check("rate_load data", 64'(rateData), 64'(rateQ.pop_front()));
         end
      end
   end

   initial begin
      doReset(3);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0);

      // Same-rate request is accepted silently.
      applyStimulus(0, 0, 1, 10);
      repeat (3) applyStimulus(0, 1, 0, 0);

      // Back-to-back invalid requests.
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 1, 11);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);

      // Normal change to 5 with strobes overlapping flush and apply.
      applyStimulus(1, 0, 1, 5);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0);
      repeat (F) applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 1, 0, 0);
      for (int i = 0; i < S + 1; i++) begin
         applyStimulus(bit'($urandom_range(0, 1)), 1, 0, 0);
         applyStimulus(bit'($urandom_range(0, 1)), 0, 0, 0);
      end
      repeat (3) applyStimulus(0, 0, 0, 0);

      // Randomised traffic, including requests while busy.
      for (int i = 0; i < 800; i++) begin
         applyStimulus(bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 7) == 0), $urandom_range(0, 12));
      end
      for (int i = 0; i < 200 && accT >= 0; i++) applyStimulus(0, 1, 0, 0);

      // Reset in the middle of settling after applying rate 3.
      doReset(2);
      applyStimulus(0, 0, 1, 3);
      applyStimulus(0, 1, 0, 0);
      repeat (F) applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      repeat (3) applyStimulus(1, 1, 0, 0);
      doReset(2);
      applyStimulus(0, 1, 0, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 1, 0, 0);
      applyStimulus(0, 0, 0, 0);

      @(negedge clk);
      #1;
      check("rate loads outstanding", 64'(rateQ.size()), 64'(0));
      check("expected queue drained", 64'(expQ.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
